// File: rtl/counter_monitor.sv
// Observer for a 4-bit up/down counter: classifies transitions, keeps wrap tallies and queues events.
// Optional direction checking is enabled by defining COUNTER_MONITOR_DIR_CHECK_EN.
module counter_monitor #(
  parameter int WIDTH   = 4,
  parameter int TALLY_W = 8
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               smp_valid,
  input  logic [WIDTH-1:0]   count_in,
  input  logic               chnge_in,
  input  logic [WIDTH-1:0]   match_val,
  input  logic               clear,
  output logic               wrap_up,
  output logic               wrap_dn,
  output logic               jump,
  output logic               match,
  output logic [TALLY_W-1:0] up_tally,
  output logic [TALLY_W-1:0] dn_tally,
  output logic               evt_valid,
  output logic [1:0]         evt_code,
  output logic [WIDTH-1:0]   evt_value,
  input  logic               evt_ready,
  output logic               evt_ovf,
  output logic               dir_err
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  localparam logic [1:0] CODE_WRAP_UP = 2'd0;
  localparam logic [1:0] CODE_WRAP_DN = 2'd1;
  localparam logic [1:0] CODE_JUMP    = 2'd2;
  localparam logic [1:0] CODE_MATCH   = 2'd3;

  localparam logic [WIDTH-1:0]   CNT_ZERO  = '0;
  localparam logic [WIDTH-1:0]   CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               wrapUp_q, wrapUp_d;
  logic               wrapDn_q, wrapDn_d;
  logic               jump_q, jump_d;
  logic               match_q, match_d;
  logic [TALLY_W-1:0] upTally_q, upTally_d;
  logic [TALLY_W-1:0] dnTally_q, dnTally_d;
  logic               evtValid_q, evtValid_d;
  logic [1:0]         evtCode_q, evtCode_d;
  logic [WIDTH-1:0]   evtValue_q, evtValue_d;
  logic               evtOvf_q, evtOvf_d;
  logic               dirErr_q, dirErr_d;

  logic [WIDTH-1:0] diff;
  logic             isTrack, isWrapUp, isWrapDn, isJump, isMatch, dirFault;

  // Wraps share diff 1 / max with plain steps, so the jump test only needs diff.
  assign diff     = count_in - prev_q;
  assign isTrack  = (state_q == ST_TRACK);
  assign isWrapUp = isTrack && (prev_q == CNT_MAX) && (count_in == CNT_ZERO);
  assign isWrapDn = isTrack && (prev_q == CNT_ZERO) && (count_in == CNT_MAX);
  assign isJump   = isTrack && (diff != CNT_ZERO) && (diff != CNT_ONE) && (diff != CNT_MAX);
  assign isMatch  = (count_in == match_val);

`ifdef COUNTER_MONITOR_DIR_CHECK_EN
  assign dirFault = isTrack && (((diff == CNT_ONE) && !chnge_in) ||
                                ((diff == CNT_MAX) && chnge_in));
`else
  logic unusedChnge;
  assign unusedChnge = chnge_in;
  assign dirFault    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    wrapUp_d   = 1'b0;
    wrapDn_d   = 1'b0;
    jump_d     = 1'b0;
    match_d    = 1'b0;
    upTally_d  = upTally_q;
    dnTally_d  = dnTally_q;
    evtValid_d = evtValid_q && !evt_ready;
    evtCode_d  = evtCode_q;
    evtValue_d = evtValue_q;
    evtOvf_d   = evtOvf_q;
    dirErr_d   = dirErr_q;
    if (clear) begin
      state_d   = ST_INIT;
      upTally_d = '0;
      dnTally_d = '0;
      evtOvf_d  = 1'b0;
      dirErr_d  = 1'b0;
    end else if (smp_valid) begin
      state_d  = ST_TRACK;
      prev_d   = count_in;
      wrapUp_d = isWrapUp;
      wrapDn_d = isWrapDn;
      jump_d   = isJump;
      match_d  = isMatch;
      dirErr_d = dirErr_q | dirFault;
      if (isWrapUp && (upTally_q != TALLY_MAX)) upTally_d = upTally_q + 1'b1;
      if (isWrapDn && (dnTally_q != TALLY_MAX)) dnTally_d = dnTally_q + 1'b1;
      // Single-entry record: load when empty or draining, otherwise drop and flag.
      if (isJump || isWrapUp || isWrapDn || isMatch) begin
        if (!evtValid_q || evt_ready) begin
          evtValid_d = 1'b1;
          evtValue_d = count_in;
          if (isJump)        evtCode_d = CODE_JUMP;
          else if (isWrapUp) evtCode_d = CODE_WRAP_UP;
          else if (isWrapDn) evtCode_d = CODE_WRAP_DN;
          else               evtCode_d = CODE_MATCH;
        end else begin
          evtOvf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      prev_q     <= '0;
      wrapUp_q   <= 1'b0;
      wrapDn_q   <= 1'b0;
      jump_q     <= 1'b0;
      match_q    <= 1'b0;
      upTally_q  <= '0;
      dnTally_q  <= '0;
      evtValid_q <= 1'b0;
      evtCode_q  <= '0;
      evtValue_q <= '0;
      evtOvf_q   <= 1'b0;
      dirErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      wrapUp_q   <= wrapUp_d;
      wrapDn_q   <= wrapDn_d;
      jump_q     <= jump_d;
      match_q    <= match_d;
      upTally_q  <= upTally_d;
      dnTally_q  <= dnTally_d;
      evtValid_q <= evtValid_d;
      evtCode_q  <= evtCode_d;
      evtValue_q <= evtValue_d;
      evtOvf_q   <= evtOvf_d;
      dirErr_q   <= dirErr_d;
    end
  end

  assign wrap_up   = wrapUp_q;
  assign wrap_dn   = wrapDn_q;
  assign jump      = jump_q;
  assign match     = match_q;
  assign up_tally  = upTally_q;
  assign dn_tally  = dnTally_q;
  assign evt_valid = evtValid_q;
  assign evt_code  = evtCode_q;
  assign evt_value = evtValue_q;
  assign evt_ovf   = evtOvf_q;
  assign dir_err   = dirErr_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed self-checking bench for counter_monitor; expected values are hand-computed per vector.
module tb_counter_monitor;

  logic       CLK = 1'b0;
  logic       reset, smp_valid, chnge_in, clear, evt_ready;
  logic [3:0] count_in, match_val;
  logic       wrap_up, wrap_dn, jump, match, evt_valid, evt_ovf, dir_err;
  logic [7:0] up_tally, dn_tally;
  logic [1:0] evt_code;
  logic [3:0] evt_value;

  int checks = 0;
  int errors = 0;
  logic dirExp;

  counter_monitor #(.WIDTH(4), .TALLY_W(8)) dut (
    .CLK(CLK), .reset(reset), .smp_valid(smp_valid), .count_in(count_in),
    .chnge_in(chnge_in), .match_val(match_val), .clear(clear),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn), .jump(jump), .match(match),
    .up_tally(up_tally), .dn_tally(dn_tally), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_value(evt_value), .evt_ready(evt_ready),
    .evt_ovf(evt_ovf), .dir_err(dir_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock with the given sample; outputs are looked at 1 ns after the edge.
  task automatic applyStimulus(input logic valid, input logic [3:0] value);
    smp_valid = valid;
    count_in  = value;
    @(posedge CLK);
    #1;
    smp_valid = 1'b0;
  endtask

  task automatic doClear();
    clear = 1'b1;
    @(posedge CLK);
    #1;
    clear = 1'b0;
  endtask

  initial begin
`ifdef COUNTER_MONITOR_DIR_CHECK_EN
    dirExp = 1'b1;
`else
    dirExp = 1'b0;
`endif
    reset = 1'b0; smp_valid = 1'b0; chnge_in = 1'b1; clear = 1'b0;
    evt_ready = 1'b1; count_in = 4'd0; match_val = 4'd9;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_evt_valid", evt_valid, 0);
    checkOutput("rst_up_tally", up_tally, 0);
    checkOutput("rst_pulses", {wrap_up, wrap_dn, jump, match}, 0);
    reset = 1'b1;

    // Plain counting from reset: first sample is silent, steps are not events.
    applyStimulus(1, 4'd0);
    checkOutput("first_pulses", {wrap_up, wrap_dn, jump, match}, 0);
    applyStimulus(1, 4'd1);
    applyStimulus(1, 4'd2);
    checkOutput("step_pulses", {wrap_up, wrap_dn, jump, match}, 0);
    checkOutput("step_tallies", {up_tally, dn_tally}, 0);
    checkOutput("step_evt_valid", evt_valid, 0);

    // Wrap up with a ready consumer.
    doClear();
    applyStimulus(1, 4'd14);
    applyStimulus(1, 4'd15);
    checkOutput("pre_wrap_up", wrap_up, 0);
    applyStimulus(1, 4'd0);
    checkOutput("wrap_up_pulse", wrap_up, 1);
    checkOutput("wrap_up_tally", up_tally, 1);
    checkOutput("wrap_up_record", {evt_valid, evt_code, evt_value}, {1'b1, 2'd0, 4'd0});
    applyStimulus(1, 4'd1);
    checkOutput("wrap_up_after", {wrap_up, evt_valid}, 0);

    // Wrap down held by a stalled consumer.
    doClear();
    checkOutput("clear_up_tally", up_tally, 0);
    evt_ready = 1'b0;
    applyStimulus(1, 4'd1);
    applyStimulus(1, 4'd0);
    applyStimulus(1, 4'd15);
    checkOutput("wrap_dn_pulse", {wrap_dn, dn_tally}, {1'b1, 8'd1});
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 4'd3);
      checkOutput("wrap_dn_hold", {evt_valid, evt_code, evt_value}, {1'b1, 2'd1, 4'd15});
    end
    checkOutput("wrap_dn_idle_pulse", wrap_dn, 0);
    checkOutput("wrap_dn_no_ovf", evt_ovf, 0);
    evt_ready = 1'b1;
    applyStimulus(0, 4'd3);
    checkOutput("wrap_dn_drained", evt_valid, 0);

    // Jump with match, then an overflowing wrap, then a same-cycle drain/reload.
    doClear();
    evt_ready = 1'b0;
    match_val = 4'd11;
    applyStimulus(1, 4'd5);
    applyStimulus(1, 4'd6);
    applyStimulus(1, 4'd11);
    checkOutput("jump_match_pulses", {jump, match}, 2'b11);
    checkOutput("jump_record", {evt_valid, evt_code, evt_value}, {1'b1, 2'd2, 4'd11});
    applyStimulus(1, 4'd12);
    applyStimulus(1, 4'd13);
    applyStimulus(1, 4'd14);
    applyStimulus(1, 4'd15);
    checkOutput("pre_ovf", evt_ovf, 0);
    applyStimulus(1, 4'd0);
    checkOutput("ovf_set", {wrap_up, evt_ovf}, 2'b11);
    checkOutput("ovf_record_kept", {evt_valid, evt_code, evt_value}, {1'b1, 2'd2, 4'd11});
    match_val = 4'd1;
    evt_ready = 1'b1;
    applyStimulus(1, 4'd1);
    checkOutput("reload_record", {evt_valid, evt_code, evt_value}, {1'b1, 2'd3, 4'd1});
    checkOutput("ovf_sticky", evt_ovf, 1);
    applyStimulus(0, 4'd1);
    checkOutput("reload_drained", evt_valid, 0);

    // Saturation: 300 up wraps and 300 down wraps.
    doClear();
    checkOutput("clear_ovf", evt_ovf, 0);
    match_val = 4'd9;
    applyStimulus(1, 4'd15);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 4'd0);
      if (i == 253) checkOutput("tally_254", up_tally, 254);
      if (i == 254) checkOutput("tally_255", up_tally, 255);
      applyStimulus(1, 4'd15);
    end
    checkOutput("tally_sat", {up_tally, dn_tally}, {8'd255, 8'd255});
    doClear();
    checkOutput("tally_cleared", {up_tally, dn_tally}, 0);
    applyStimulus(1, 4'd5);
    checkOutput("init_after_clear", jump, 0);
    applyStimulus(1, 4'd7);
    checkOutput("track_after_clear", jump, 1);

    // Direction check, then reset mid-run with a pending record.
    doClear();
    chnge_in = 1'b0;
    applyStimulus(1, 4'd3);
    checkOutput("dir_init", dir_err, 0);
    applyStimulus(1, 4'd4);
    checkOutput("dir_up_wrong", dir_err, {31'd0, dirExp});
    applyStimulus(1, 4'd4);
    applyStimulus(1, 4'd3);
    checkOutput("dir_sticky", dir_err, {31'd0, dirExp});
    evt_ready = 1'b0;
    applyStimulus(1, 4'd9);
    checkOutput("pre_reset_record", {jump, evt_valid}, 2'b11);
    reset = 1'b0;
    @(posedge CLK);
    #1;
    reset = 1'b1;
    checkOutput("midreset_outputs", {wrap_up, wrap_dn, jump, match, evt_valid, evt_code,
                                     evt_value, evt_ovf, dir_err, up_tally, dn_tally}, 0);
    evt_ready = 1'b1;
    match_val = 4'd7;
    applyStimulus(1, 4'd7);
    checkOutput("init_match", {jump, match, evt_valid, evt_code}, {1'b0, 1'b1, 1'b1, 2'd3});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
